// File: rtl/rc5_pkg.sv
// Shared types and helpers for the RC5 cipher core: FSM state encoding,
// parameter checks and width-generic rotate functions.
package rc5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } rc5_state_e;

  localparam int RC5_W_DEFAULT = 32;
  localparam int RC5_R_DEFAULT = 12;

  // Round-key table depth T = 2R+2.
  function automatic int rc5_key_depth(input int r);
    return 2 * r + 2;
  endfunction

  function automatic bit rc5_legal_w(input int w);
    return (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic logic [63:0] rc5_mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Rotate the low w bits of x left by the low log2(w) bits of amt.
  function automatic logic [63:0] rc5_rotl(input logic [63:0] x, input logic [63:0] amt,
                                           input int w);
    logic [63:0] m;
    logic [63:0] xm;
    int s;
    m  = rc5_mask(w);
    xm = x & m;
    s  = int'(amt & 64'(w - 1));
    if (s == 0) return xm;
    return ((xm << s) | (xm >> (w - s))) & m;
  endfunction

  // Rotate the low w bits of x right by the low log2(w) bits of amt.
  function automatic logic [63:0] rc5_rotr(input logic [63:0] x, input logic [63:0] amt,
                                           input int w);
    logic [63:0] m;
    logic [63:0] xm;
    int s;
    m  = rc5_mask(w);
    xm = x & m;
    s  = int'(amt & 64'(w - 1));
    if (s == 0) return xm;
    return ((xm >> s) | (xm << (w - s))) & m;
  endfunction

endpackage

// File: rtl/rc5_cipher_core_if.sv
// Host-side bus of the RC5 core: block in/out handshakes, mode, key-table
// write port and status.
interface rc5_cipher_core_if
  import rc5_pkg::*;
#(
  parameter int W = RC5_W_DEFAULT,
  parameter int R = RC5_R_DEFAULT
);
  localparam int T  = rc5_key_depth(R);
  localparam int AW = $clog2(T);

  logic [2*W-1:0] din;
  logic           di_vld;
  logic           di_rdy;
  logic           mode;
  logic [2*W-1:0] dout;
  logic           do_vld;
  logic           do_rdy;
  logic           key_we;
  logic [AW-1:0]  key_addr;
  logic [W-1:0]   key_din;
  logic           busy;

  modport master (
    output din, di_vld, mode, do_rdy, key_we, key_addr, key_din,
    input  di_rdy, dout, do_vld, busy
  );

  modport slave (
    input  din, di_vld, mode, do_rdy, key_we, key_addr, key_din,
    output di_rdy, dout, do_vld, busy
  );
endinterface

// File: rtl/rc5_round.sv
// One full RC5 round, combinational; mode selects encrypt (0) or the
// inverse decrypt round (1).
module rc5_round
  import rc5_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_s_even,
  input  logic [W-1:0] i_s_odd,
  input  logic         i_mode,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);
  logic [W-1:0] w_enc_a;
  logic [W-1:0] w_enc_b;
  logic [W-1:0] w_dec_a;
  logic [W-1:0] w_dec_b;

  // Encrypt: A first, then B using the fresh A.
  assign w_enc_a = W'(rc5_rotl(64'(i_a ^ i_b), 64'(i_b), W)) + i_s_even;
  assign w_enc_b = W'(rc5_rotl(64'(i_b ^ w_enc_a), 64'(w_enc_a), W)) + i_s_odd;

  // Decrypt undoes the encrypt steps in reverse: B first, then A using the fresh B.
  assign w_dec_b = W'(rc5_rotr(64'(i_b - i_s_odd), 64'(i_a), W)) ^ i_a;
  assign w_dec_a = W'(rc5_rotr(64'(i_a - i_s_even), 64'(w_dec_b), W)) ^ w_dec_b;

  assign o_a = i_mode ? w_dec_a : w_enc_a;
  assign o_b = i_mode ? w_dec_b : w_enc_b;
endmodule

// File: rtl/rc5_cipher_core.sv
// Iterative RC5-W/R engine: one round per clock, per-block encrypt/decrypt,
// runtime-loadable round-key table writable only while idle.
module rc5_cipher_core
  import rc5_pkg::*;
#(
  parameter int W = RC5_W_DEFAULT,
  parameter int R = RC5_R_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  rc5_cipher_core_if.slave bus
);
  localparam int T  = rc5_key_depth(R);
  localparam int AW = $clog2(T);

  if (!rc5_legal_w(W) || (R < 1) || (R > 255)) begin : g_param_check
    $error("rc5_cipher_core: W must be 16/32/64 and R within 1..255");
  end

  rc5_state_e     r_state;
  rc5_state_e     w_state_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [7:0]     r_idx;
  logic           r_mode;
  logic [2*W-1:0] r_dout;
  logic [W-1:0]   r_s [T];

  logic           w_key_wr;
  logic           w_last;
  logic [AW-1:0]  w_addr_even;
  logic [AW-1:0]  w_addr_odd;
  logic [W-1:0]   w_din_a;
  logic [W-1:0]   w_din_b;
  logic [W-1:0]   w_rnd_a;
  logic [W-1:0]   w_rnd_b;
  logic [W-1:0]   w_post_a;
  logic [W-1:0]   w_post_b;

  assign w_din_a     = bus.din[W-1:0];
  assign w_din_b     = bus.din[2*W-1:W];
  assign w_key_wr    = (r_state == ST_IDLE) && bus.key_we && (32'(bus.key_addr) < T);
  assign w_last      = r_mode ? (r_idx == 8'd1) : (r_idx == 8'(R));
  assign w_addr_even = AW'({r_idx, 1'b0});
  assign w_addr_odd  = AW'({r_idx, 1'b1});
  assign w_post_a    = r_mode ? (r_a - r_s[0]) : r_a;
  assign w_post_b    = r_mode ? (r_b - r_s[1]) : r_b;
  assign bus.dout    = r_dout;

  rc5_round #(.W(W)) u_round (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_s_even (r_s[w_addr_even]),
    .i_s_odd  (r_s[w_addr_odd]),
    .i_mode   (r_mode),
    .o_a      (w_rnd_a),
    .o_b      (w_rnd_b)
  );

  // Key table: one register per entry, cleared by reset, written only in IDLE.
  for (genvar gi = 0; gi < T; gi++) begin : g_key
    always_ff @(posedge clk or posedge clr) begin
      if (clr) r_s[gi] <= '0;
      else if (w_key_wr && (bus.key_addr == AW'(gi))) r_s[gi] <= bus.key_din;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; di_rdy depends on state alone.
  always_comb begin
    w_state_next = r_state;
    bus.di_rdy   = 1'b0;
    bus.do_vld   = 1'b0;
    bus.busy     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.di_rdy = 1'b1;
        bus.busy   = 1'b0;
        if (bus.di_vld) w_state_next = ST_ROUND;
      end
      ST_ROUND: if (w_last) w_state_next = ST_POST;
      ST_POST:  w_state_next = ST_DONE;
      ST_DONE: begin
        bus.do_vld = 1'b1;
        if (bus.do_rdy) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture/whitening, one round per cycle, final un-whitening into dout.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_mode <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.di_vld) begin
          r_mode <= bus.mode;
          if (bus.mode) begin
            r_a   <= w_din_a;
            r_b   <= w_din_b;
            r_idx <= 8'(R);
          end else begin
            r_a   <= w_din_a + r_s[0];
            r_b   <= w_din_b + r_s[1];
            r_idx <= 8'd1;
          end
        end
        ST_ROUND: begin
          r_a <= w_rnd_a;
          r_b <= w_rnd_b;
          // Hold the index on the last round so it never addresses past the table.
          if (!w_last) r_idx <= r_mode ? (r_idx - 8'd1) : (r_idx + 8'd1);
        end
        ST_POST: r_dout <= {w_post_b, w_post_a};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rc5_cipher_core.sv
// Self-checking bench for rc5_cipher_core at W=32/R=12, W=16/R=8, W=64/R=20,
// with an arithmetic RC5 reference model.
module tb_rc5_cipher_core;
  logic clk;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] ks [64];

  rc5_cipher_core_if #(.W(32), .R(12)) i32 ();
  rc5_cipher_core_if #(.W(16), .R(8))  i16 ();
  rc5_cipher_core_if #(.W(64), .R(20)) i64 ();

  rc5_cipher_core #(.W(32), .R(12)) u_dut32 (.clk(clk), .clr(clr), .bus(i32.slave));
  rc5_cipher_core #(.W(16), .R(8))  u_dut16 (.clk(clk), .clr(clr), .bus(i16.slave));
  rc5_cipher_core #(.W(64), .R(20)) u_dut64 (.clk(clk), .clr(clr), .bus(i64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_msk(input int w);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < w; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_rotl(input logic [63:0] x, input logic [63:0] amt, input int w);
    logic [63:0] y;
    int s;
    y = '0;
    s = int'(amt % 64'(w));
    for (int k = 0; k < w; k++) y[(k + s) % w] = x[k];
    return y;
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] x, input logic [63:0] amt, input int w);
    logic [63:0] y;
    int s;
    y = '0;
    s = int'(amt % 64'(w));
    for (int k = 0; k < w; k++) y[k] = x[(k + s) % w];
    return y;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] blk, input int w, input int r);
    logic [63:0] m, a, b;
    m = m_msk(w);
    a = blk[63:0] & m;
    b = 64'(blk >> w) & m;
    a = (a + ks[0]) & m;
    b = (b + ks[1]) & m;
    for (int i = 1; i <= r; i++) begin
      a = (m_rotl(a ^ b, b, w) + ks[2*i]) & m;
      b = (m_rotl(b ^ a, a, w) + ks[2*i+1]) & m;
    end
    return (128'(b) << w) | 128'(a);
  endfunction

  function automatic logic [127:0] m_dec(input logic [127:0] blk, input int w, input int r);
    logic [63:0] m, a, b;
    m = m_msk(w);
    a = blk[63:0] & m;
    b = 64'(blk >> w) & m;
    for (int i = r; i >= 1; i--) begin
      b = m_rotr((b - ks[2*i+1]) & m, a, w) ^ a;
      a = m_rotr((a - ks[2*i]) & m, b, w) ^ b;
    end
    b = (b - ks[1]) & m;
    a = (a - ks[0]) & m;
    return (128'(b) << w) | 128'(a);
  endfunction

  task automatic rand_table(input int w, input int t);
    for (int k = 0; k < 64; k++) ks[k] = (k < t) ? ({$urandom, $urandom} & m_msk(w)) : 64'd0;
  endtask

  // Standard RC5-32/12 key schedule for a 16-byte all-zero key.
  task automatic std_key();
    logic [63:0] l [4];
    logic [63:0] a, b;
    int i, j;
    for (int k = 0; k < 64; k++) ks[k] = 64'd0;
    for (int k = 0; k < 4; k++) l[k] = 64'd0;
    ks[0] = 64'hB7E15163;
    for (int k = 1; k < 26; k++) ks[k] = (ks[k-1] + 64'h9E3779B9) & 64'hFFFFFFFF;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      ks[i] = m_rotl((ks[i] + a + b) & 64'hFFFFFFFF, 64'd3, 32);
      a = ks[i];
      l[j] = m_rotl((l[j] + a + b) & 64'hFFFFFFFF, (a + b) & 64'hFFFFFFFF, 32);
      b = l[j];
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic load32();
    for (int k = 0; k < 26; k++) begin
      i32.key_we = 1'b1; i32.key_addr = 5'(k); i32.key_din = ks[k][31:0];
      @(posedge clk); #1;
    end
    i32.key_we = 1'b0;
  endtask

  task automatic load16();
    for (int k = 0; k < 18; k++) begin
      i16.key_we = 1'b1; i16.key_addr = 5'(k); i16.key_din = ks[k][15:0];
      @(posedge clk); #1;
    end
    i16.key_we = 1'b0;
  endtask

  task automatic load64();
    for (int k = 0; k < 42; k++) begin
      i64.key_we = 1'b1; i64.key_addr = 6'(k); i64.key_din = ks[k];
      @(posedge clk); #1;
    end
    i64.key_we = 1'b0;
  endtask

  // One block through the 32-bit core; optionally pulses a key write on cycle 'poke'
  // (0 = same edge as the accept). lat is cycles from accept to do_vld, -1 on timeout.
  task automatic xfer32(input logic md, input logic [127:0] blk, input int poke,
                        input logic [4:0] kaddr, input logic [31:0] kval,
                        output logic [127:0] res, output int lat, output int bc);
    lat = -1; bc = 0;
    i32.key_addr = kaddr; i32.key_din = kval; i32.key_we = (poke == 0);
    i32.din = blk[63:0]; i32.mode = md; i32.di_vld = 1'b1;
    @(posedge clk); #1;
    i32.di_vld = 1'b0; i32.key_we = 1'b0;
    if (i32.busy) bc++;
    for (int n = 1; n <= 100; n++) begin
      i32.key_we = (n == poke);
      @(posedge clk); #1;
      if (i32.busy) bc++;
      if (i32.do_vld) begin lat = n; break; end
    end
    i32.key_we = 1'b0;
    res = 128'(i32.dout);
    i32.do_rdy = 1'b1; @(posedge clk); #1; i32.do_rdy = 1'b0;
    $display("xfer32 mode=%0d in=%h out=%h lat=%0d", md, blk[63:0], res[63:0], lat);
  endtask

  task automatic xfer16(input logic md, input logic [127:0] blk, output logic [127:0] res, output int lat);
    lat = -1;
    i16.din = blk[31:0]; i16.mode = md; i16.di_vld = 1'b1;
    @(posedge clk); #1;
    i16.di_vld = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (i16.do_vld) begin lat = n; break; end
    end
    res = 128'(i16.dout);
    i16.do_rdy = 1'b1; @(posedge clk); #1; i16.do_rdy = 1'b0;
    $display("xfer16 mode=%0d in=%h out=%h lat=%0d", md, blk[31:0], res[31:0], lat);
  endtask

  task automatic xfer64(input logic md, input logic [127:0] blk, output logic [127:0] res, output int lat);
    lat = -1;
    i64.din = blk; i64.mode = md; i64.di_vld = 1'b1;
    @(posedge clk); #1;
    i64.di_vld = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (i64.do_vld) begin lat = n; break; end
    end
    res = i64.dout;
    i64.do_rdy = 1'b1; @(posedge clk); #1; i64.do_rdy = 1'b0;
    $display("xfer64 mode=%0d in=%h out=%h lat=%0d", md, blk, res, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1;
    i32.din = '0; i32.di_vld = 0; i32.mode = 0; i32.do_rdy = 0; i32.key_we = 0; i32.key_addr = '0; i32.key_din = '0;
    i16.din = '0; i16.di_vld = 0; i16.mode = 0; i16.do_rdy = 0; i16.key_we = 0; i16.key_addr = '0; i16.key_din = '0;
    i64.din = '0; i64.di_vld = 0; i64.mode = 0; i64.do_rdy = 0; i64.key_we = 0; i64.key_addr = '0; i64.key_din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (i32.di_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_di_rdy: got %b want 1", i32.di_rdy); end
    n_cmp++; if (i32.do_vld !== 1'b0) begin n_bad++; $display("FAIL reset_do_vld: got %b want 0", i32.do_vld); end
    n_cmp++; if (i32.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", i32.busy); end
    n_cmp++; if (i32.dout !== 64'd0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", i32.dout); end
    clr = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({i32.di_rdy, i32.busy} !== 2'b10) begin n_bad++; $display("FAIL reset_release: got %b want 10", {i32.di_rdy, i32.busy}); end
  endtask

  task automatic test_zero_table();
    logic [127:0] ct; int lat, bc;
    for (int k = 0; k < 64; k++) ks[k] = 64'd0;
    xfer32(1'b0, 128'd0, -1, 5'd0, 32'd0, ct, lat, bc);
    n_cmp++; if (ct !== 128'd0) begin n_bad++; $display("FAIL zero_dout: got %h want 0", ct); end
    n_cmp++; if (lat != 13) begin n_bad++; $display("FAIL zero_latency: got %0d want 13", lat); end
    n_cmp++; if (bc != 14) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d want 14", bc); end
  endtask

  task automatic test_std_vector();
    logic [127:0] ct, rt; int lat, bc;
    std_key();
    load32();
    xfer32(1'b0, 128'd0, -1, 5'd0, 32'd0, ct, lat, bc);
    n_cmp++; if (ct !== 128'h6D8F4B15EEDBA521) begin n_bad++; $display("FAIL std_enc: got %h want 6d8f4b15eedba521", ct); end
    n_cmp++; if (ct !== m_enc(128'd0, 32, 12)) begin n_bad++; $display("FAIL std_enc_model: got %h want %h", ct, m_enc(128'd0, 32, 12)); end
    xfer32(1'b1, 128'h6D8F4B15EEDBA521, -1, 5'd0, 32'd0, rt, lat, bc);
    n_cmp++; if (rt !== 128'd0) begin n_bad++; $display("FAIL std_dec: got %h want 0", rt); end
  endtask

  task automatic test_round_trip32();
    logic [127:0] pt, ct, rt, ex; int lat, bc;
    for (int k = 0; k < 1000; k++) begin
      if (k % 100 == 0) begin rand_table(32, 26); load32(); end
      pt = 128'({$urandom, $urandom});
      xfer32(1'b0, pt, -1, 5'd0, 32'd0, ct, lat, bc);
      ex = m_enc(pt, 32, 12);
      n_cmp++; if (ct !== ex || lat != 13) begin n_bad++; $display("FAIL rt32_enc: got %h lat %0d want %h lat 13", ct, lat, ex); end
      xfer32(1'b1, ct, -1, 5'd0, 32'd0, rt, lat, bc);
      n_cmp++; if (rt !== pt || rt !== m_dec(ex, 32, 12)) begin n_bad++; $display("FAIL rt32_dec: got %h want %h", rt, pt); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, d0; int lat;
    rand_table(32, 26); load32();
    pt = 128'({$urandom, $urandom});
    i32.din = pt[63:0]; i32.mode = 1'b0; i32.di_vld = 1'b1;
    @(posedge clk); #1;
    i32.di_vld = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (i32.do_vld) begin lat = n; break; end
    end
    d0 = 128'(i32.dout);
    n_cmp++; if (d0 !== m_enc(pt, 32, 12) || lat != 13) begin n_bad++; $display("FAIL bp_result: got %h lat %0d want %h lat 13", d0, lat, m_enc(pt, 32, 12)); end
    i32.din = ~pt[63:0]; i32.di_vld = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (128'(i32.dout) !== d0 || i32.di_rdy !== 1'b0 || i32.do_vld !== 1'b1) begin
        n_bad++; $display("FAIL bp_stall: cycle %0d dout %h di_rdy %b do_vld %b want %h 0 1", n, i32.dout, i32.di_rdy, i32.do_vld, d0);
      end
    end
    i32.di_vld = 1'b0; i32.do_rdy = 1'b1;
    @(posedge clk); #1;
    i32.do_rdy = 1'b0;
    n_cmp++; if ({i32.di_rdy, i32.busy, i32.do_vld} !== 3'b100) begin n_bad++; $display("FAIL bp_release: got %b want 100", {i32.di_rdy, i32.busy, i32.do_vld}); end
    n_cmp++; if (128'(i32.dout) !== d0) begin n_bad++; $display("FAIL bp_dout_hold: got %h want %h", i32.dout, d0); end
    @(posedge clk); #1;
    n_cmp++; if (i32.busy !== 1'b0) begin n_bad++; $display("FAIL bp_no_accept: busy got %b want 0", i32.busy); end
    $display("backpressure block in=%h out=%h", pt[63:0], d0[63:0]);
  endtask

  task automatic test_key_write_busy();
    logic [127:0] pt, ct, ex; int lat, bc;
    logic [31:0] nv;
    rand_table(32, 26); load32();
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, 3, 5'd2, 32'hFFFFFFFF, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL kw_busy_same: got %h want %h", ct, ex); end
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, -1, 5'd0, 32'd0, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL kw_busy_next: got %h want %h", ct, ex); end
    nv = $urandom;
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, 0, 5'd0, nv, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL kw_accept_old: got %h want %h", ct, ex); end
    ks[0] = 64'(nv);
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, -1, 5'd0, 32'd0, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL kw_accept_new: got %h want %h", ct, ex); end
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, 0, 5'd27, $urandom, ct, lat, bc);
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, -1, 5'd0, 32'd0, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL kw_addr_range: got %h want %h", ct, ex); end
  endtask

  task automatic test_reset_mid_block();
    logic [127:0] pt, ct, ex; int lat, bc;
    rand_table(32, 26); load32();
    pt = 128'({$urandom, $urandom});
    i32.din = pt[63:0]; i32.mode = 1'b0; i32.di_vld = 1'b1;
    @(posedge clk); #1;
    i32.di_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    n_cmp++; if ({i32.di_rdy, i32.do_vld, i32.busy} !== 3'b100) begin n_bad++; $display("FAIL mid_reset_flags: got %b want 100", {i32.di_rdy, i32.do_vld, i32.busy}); end
    n_cmp++; if (i32.dout !== 64'd0) begin n_bad++; $display("FAIL mid_reset_dout: got %h want 0", i32.dout); end
    #1;
    clr = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) ks[k] = 64'd0;
    xfer32(1'b0, 128'd0, -1, 5'd0, 32'd0, ct, lat, bc);
    n_cmp++; if (ct !== 128'd0) begin n_bad++; $display("FAIL mid_reset_zero: got %h want 0", ct); end
    pt = 128'({$urandom, $urandom});
    xfer32(1'b0, pt, -1, 5'd0, 32'd0, ct, lat, bc);
    ex = m_enc(pt, 32, 12);
    n_cmp++; if (ct !== ex) begin n_bad++; $display("FAIL mid_reset_table: got %h want %h", ct, ex); end
  endtask

  task automatic test_round_trip16();
    logic [127:0] pt, ct, rt, ex; int lat;
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 0) begin rand_table(16, 18); load16(); end
      pt = 128'($urandom);
      xfer16(1'b0, pt, ct, lat);
      ex = m_enc(pt, 16, 8);
      n_cmp++; if (ct !== ex || lat != 9) begin n_bad++; $display("FAIL rt16_enc: got %h lat %0d want %h lat 9", ct, lat, ex); end
      xfer16(1'b1, ct, rt, lat);
      n_cmp++; if (rt !== pt) begin n_bad++; $display("FAIL rt16_dec: got %h want %h", rt, pt); end
    end
  endtask

  task automatic test_round_trip64();
    logic [127:0] pt, ct, rt, ex; int lat;
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 0) begin rand_table(64, 42); load64(); end
      pt = {$urandom, $urandom, $urandom, $urandom};
      xfer64(1'b0, pt, ct, lat);
      ex = m_enc(pt, 64, 20);
      n_cmp++; if (ct !== ex || lat != 21) begin n_bad++; $display("FAIL rt64_enc: got %h lat %0d want %h lat 21", ct, lat, ex); end
      xfer64(1'b1, ct, rt, lat);
      n_cmp++; if (rt !== pt) begin n_bad++; $display("FAIL rt64_dec: got %h want %h", rt, pt); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_table();
    test_std_vector();
    test_round_trip32();
    test_backpressure();
    test_key_write_busy();
    test_reset_mid_block();
    test_round_trip16();
    test_round_trip64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rc5_cipher_core.md
# rc5_cipher_core

Parametrised, iterative RC5-W/R block cipher engine that performs encryption or decryption per block, selected at accept time. It replaces the fixed-width, fixed-direction encrypt and decrypt pair with one core. The core has a runtime-loadable round-key table, valid/ready handshakes on input and output, and one full round per clock. It sits between the host data path and the key-expansion logic; key expansion itself is outside this block.

## Interface
- `W`, default 32: word width; legal values 16, 32, 64. Block width is 2W. Rotate amount uses the low log2(W) bits.
- `R`, default 12: round count; legal range 1..255. Key table depth is T = 2R+2, which is 26 at the default.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `clr`, input, 1: reset, asynchronous, active-high.
- `din`, input, 2W: input block; A = din[W-1:0], B = din[2W-1:W].
- `di_vld`, input, 1: input block valid.
- `di_rdy`, output, 1: core can accept a block.
- `mode`, input, 1: 0 = encrypt, 1 = decrypt; sampled on the accept edge.
- `dout`, output, 2W: result block, same A/B packing as `din`.
- `do_vld`, output, 1: result valid.
- `do_rdy`, input, 1: downstream takes the result.
- `key_we`, input, 1: write strobe for the round-key table.
- `key_addr`, input, ceil(log2(T)): index of S[i].
- `key_din`, input, W: value written to S[key_addr].
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, ROUND, POST, DONE.
- **IDLE**
  - `di_rdy` = 1.
  - On `di_vld` & `di_rdy`: capture `mode` and go to ROUND with the round counter loaded.
  - Encrypt capture: A ← A+S[0], B ← B+S[1].
  - Decrypt capture: A and B taken raw.
- **ROUND** (one round per cycle; the counter runs i = 1..R for encrypt and i = R..1 for decrypt)
  - Encrypt round: A' = ((A^B) <<< B) + S[2i]; B' = ((B^A') <<< A') + S[2i+1].
  - Decrypt round: B' = ((B − S[2i+1]) >>> A) ^ A; A' = ((A − S[2i]) >>> B') ^ B'.
  - After the R-th round, go to POST.
- **POST**
  - Encrypt: A and B unchanged.
  - Decrypt: B ← B−S[1], A ← A−S[0].
  - Go to DONE.
- **DONE**
  - `do_vld` = 1, and `dout` = {B, A} is held stable.
  - On `do_rdy`: go to IDLE.
- **Arithmetic:** all add/sub is modulo 2^W. Rotates are by (x mod W).
- **Key table:** T registers, all 0 after reset.
  - A `key_we` write takes effect on the next edge, and only while in IDLE.
  - Writes in any other state are ignored, so the table is stable during a block.
  - `key_addr` ≥ T is ignored.
- **Simultaneous events:**
  - `key_we` and an accept on the same IDLE edge: the write lands, but the block being accepted uses the pre-write table. The capture-cycle whitening reads old S[0]/S[1].
  - `di_vld` outside IDLE is not accepted. Input is not buffered.
- **Reset:** `clr` at any time, including mid-round, returns the core to IDLE and clears the table, A, B and the counter. The in-flight block is lost with no output.

## Timing
- **Reset values:**
  - `di_rdy` = 1.
  - `do_vld` = 0.
  - `busy` = 0.
  - `dout` = 0.
- **Latency:** block accepted on edge t → `do_vld` rises after edge t+R+1. That is R+1 cycles, 13 at the default.
- **Throughput:** one block per R+3 cycles when `do_rdy` is tied high (IDLE, R rounds, POST, DONE).
- **Output stability:** `dout` changes only on the edge leaving POST. It is held through any `do_rdy`-low stall.
- **Combinational path:** `di_rdy` depends on state only, never on `di_vld`.

## Structure
- **Shared package `rc5_pkg`:**
  - State enum.
  - Rotate-left and rotate-right functions parametrised on W.
  - Legal-W check.
  - Localparam T = 2R+2.
- **Sub-module `rc5_round`:** combinational, one full round.
  - Inputs: A, B, S_even, S_odd, mode.
  - Outputs: A', B'.
  - Instantiated once.
- The top level holds the FSM, counter, key table and handshakes. It is estimated at 200–300 lines.

## Test plan
- **All-zero table, encrypt:** with W=32, R=12, no key writes, `din` = 0 → `do_vld` 13 cycles after accept with `dout` = 0. `busy` is high for 14 cycles.
- **Standard vector:** load S[0..25] from the bench model's expansion of the 16-byte all-zero key. Encrypt `din` = 0 → `dout` = 64'h6D8F4B15_EEDBA521. Decrypt that value → 0.
- **Round trip:** 1000 random blocks × random tables, each encrypted then decrypted → original block. Also run at W=16/R=8 and W=64/R=20.
- **Backpressure:** hold `do_rdy` = 0 for 20 cycles after `do_vld` → `dout` stable, `di_rdy` = 0, and a second `di_vld` is not accepted. Raise `do_rdy` → IDLE next cycle.
- **Key write while busy:** write S[2] = 32'hFFFFFFFF mid-round → the result matches the old table, and the next block uses the old S[2].
- **Reset mid-block:** assert `clr` at round 5 → all outputs at reset values immediately. The key table reads 0, and the next block with `din` = 0 gives `dout` = 0.
